// File: rtl/ps2_keymap.sv
// PS/2 set-2 scan-code decoder producing nand2tetris Hack keyboard codes.
// Optional caps-lock tracking is enabled by defining KBD_CAPSLOCK_EN.
module ps2_keymap (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  scan_code,
    input  logic        got_code,
    output logic [15:0] key_code,
    output logic        key_event,
    output logic        caps_active
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_EXT       = 3'd1;
    localparam logic [2:0] ST_BREAK     = 3'd2;
    localparam logic [2:0] ST_EXT_BREAK = 3'd3;
    localparam logic [2:0] ST_PAUSE     = 3'd4;

    logic [2:0] state, next_state;
    logic [2:0] pause_cnt, next_pause;
    logic       do_make, do_break, cur_ext;
    logic       lshift, rshift, shift;
    logic       caps_reg;
    logic [7:0] key_reg;
    logic       held_valid;
    logic [8:0] held_key;
    logic [8:0] mapped;
    logic       make_hit, break_hit;
    logic       plain_byte;

    // Returns {valid, value}; valid=0 means the key has no Hack code.
    function automatic logic [8:0] map_code(input logic ext, input logic [7:0] code,
                                            input logic sh, input logic caps);
        logic [8:0] r;
        logic [7:0] lb;
        r  = 9'h000;
        lb = (sh ^ caps) ? 8'h41 : 8'h61;
        if (ext) begin
            case (code)
                8'h6B: r = {1'b1, 8'd130};
                8'h75: r = {1'b1, 8'd131};
                8'h74: r = {1'b1, 8'd132};
                8'h72: r = {1'b1, 8'd133};
                8'h6C: r = {1'b1, 8'd134};
                8'h69: r = {1'b1, 8'd135};
                8'h7D: r = {1'b1, 8'd136};
                8'h7A: r = {1'b1, 8'd137};
                8'h70: r = {1'b1, 8'd138};
                8'h71: r = {1'b1, 8'd139};
                8'h5A: r = {1'b1, 8'd128};
                default: r = 9'h000;
            endcase
        end else begin
            case (code)
                8'h1C: r = {1'b1, lb + 8'd0};
                8'h32: r = {1'b1, lb + 8'd1};
                8'h21: r = {1'b1, lb + 8'd2};
                8'h23: r = {1'b1, lb + 8'd3};
                8'h24: r = {1'b1, lb + 8'd4};
                8'h2B: r = {1'b1, lb + 8'd5};
                8'h34: r = {1'b1, lb + 8'd6};
                8'h33: r = {1'b1, lb + 8'd7};
                8'h43: r = {1'b1, lb + 8'd8};
                8'h3B: r = {1'b1, lb + 8'd9};
                8'h42: r = {1'b1, lb + 8'd10};
                8'h4B: r = {1'b1, lb + 8'd11};
                8'h3A: r = {1'b1, lb + 8'd12};
                8'h31: r = {1'b1, lb + 8'd13};
                8'h44: r = {1'b1, lb + 8'd14};
                8'h4D: r = {1'b1, lb + 8'd15};
                8'h15: r = {1'b1, lb + 8'd16};
                8'h2D: r = {1'b1, lb + 8'd17};
                8'h1B: r = {1'b1, lb + 8'd18};
                8'h2C: r = {1'b1, lb + 8'd19};
                8'h3C: r = {1'b1, lb + 8'd20};
                8'h2A: r = {1'b1, lb + 8'd21};
                8'h1D: r = {1'b1, lb + 8'd22};
                8'h22: r = {1'b1, lb + 8'd23};
                8'h35: r = {1'b1, lb + 8'd24};
                8'h1A: r = {1'b1, lb + 8'd25};
                // Digits and punctuation follow shift only, never caps.
                8'h45: r = {1'b1, sh ? 8'h29 : 8'h30};
                8'h16: r = {1'b1, sh ? 8'h21 : 8'h31};
                8'h1E: r = {1'b1, sh ? 8'h40 : 8'h32};
                8'h26: r = {1'b1, sh ? 8'h23 : 8'h33};
                8'h25: r = {1'b1, sh ? 8'h24 : 8'h34};
                8'h2E: r = {1'b1, sh ? 8'h25 : 8'h35};
                8'h36: r = {1'b1, sh ? 8'h5E : 8'h36};
                8'h3D: r = {1'b1, sh ? 8'h26 : 8'h37};
                8'h3E: r = {1'b1, sh ? 8'h2A : 8'h38};
                8'h46: r = {1'b1, sh ? 8'h28 : 8'h39};
                8'h4E: r = {1'b1, sh ? 8'h5F : 8'h2D};
                8'h55: r = {1'b1, sh ? 8'h2B : 8'h3D};
                8'h41: r = {1'b1, sh ? 8'h3C : 8'h2C};
                8'h49: r = {1'b1, sh ? 8'h3E : 8'h2E};
                8'h4A: r = {1'b1, sh ? 8'h3F : 8'h2F};
                8'h4C: r = {1'b1, sh ? 8'h3A : 8'h3B};
                8'h52: r = {1'b1, sh ? 8'h22 : 8'h27};
                8'h54: r = {1'b1, sh ? 8'h7B : 8'h5B};
                8'h5B: r = {1'b1, sh ? 8'h7D : 8'h5D};
                8'h5D: r = {1'b1, sh ? 8'h7C : 8'h5C};
                8'h0E: r = {1'b1, sh ? 8'h7E : 8'h60};
                8'h29: r = {1'b1, 8'd32};
                8'h5A: r = {1'b1, 8'd128};
                8'h66: r = {1'b1, 8'd129};
                8'h76: r = {1'b1, 8'd140};
                8'h05: r = {1'b1, 8'd141};
                8'h06: r = {1'b1, 8'd142};
                8'h04: r = {1'b1, 8'd143};
                8'h0C: r = {1'b1, 8'd144};
                8'h03: r = {1'b1, 8'd145};
                8'h0B: r = {1'b1, 8'd146};
                8'h83: r = {1'b1, 8'd147};
                8'h0A: r = {1'b1, 8'd148};
                8'h01: r = {1'b1, 8'd149};
                8'h09: r = {1'b1, 8'd150};
                8'h78: r = {1'b1, 8'd151};
                8'h07: r = {1'b1, 8'd152};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    // Bytes that are protocol chatter rather than key data when no prefix is pending.
    assign plain_byte = !(scan_code == 8'hAA || scan_code == 8'hFA || scan_code == 8'hFE ||
                          scan_code == 8'hEE || scan_code == 8'h00 || scan_code == 8'hFF);

    always_comb begin
        next_state = state;
        next_pause = pause_cnt;
        do_make    = 1'b0;
        do_break   = 1'b0;
        cur_ext    = 1'b0;
        if (got_code) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == 8'hF0)      next_state = ST_BREAK;
                    else if (scan_code == 8'hE0) next_state = ST_EXT;
                    else if (scan_code == 8'hE1) begin
                        next_state = ST_PAUSE;
                        next_pause = 3'd7;
                    end else if (plain_byte)     do_make = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == 8'hF0)      next_state = ST_EXT_BREAK;
                    else if (scan_code != 8'hE0) begin
                        do_make    = 1'b1;
                        cur_ext    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (scan_code == 8'hE0)      next_state = ST_EXT_BREAK;
                    else if (scan_code != 8'hF0) begin
                        do_break   = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
                ST_EXT_BREAK: begin
                    if (scan_code != 8'hE0 && scan_code != 8'hF0) begin
                        do_break   = 1'b1;
                        cur_ext    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    next_pause = pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pause_cnt <= 3'd0;
        end else begin
            state     <= next_state;
            pause_cnt <= next_pause;
        end
    end

`ifdef KBD_CAPSLOCK_EN
    logic caps_down;

    // caps_down swallows typematic repeats so only the first make toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            caps_reg  <= 1'b0;
            caps_down <= 1'b0;
        end else if (do_make && !cur_ext && scan_code == 8'h58) begin
            if (!caps_down) caps_reg <= ~caps_reg;
            caps_down <= 1'b1;
        end else if (do_break && !cur_ext && scan_code == 8'h58) begin
            caps_down <= 1'b0;
        end
    end
`else
    assign caps_reg = 1'b0;
`endif

    assign shift     = lshift | rshift;
    assign mapped    = map_code(cur_ext, scan_code, shift, caps_reg);
    assign make_hit  = do_make & mapped[8];
    assign break_hit = do_break & held_valid & (held_key == {cur_ext, scan_code});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg    <= 8'h00;
            key_event  <= 1'b0;
            held_valid <= 1'b0;
            held_key   <= 9'h000;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
        end else begin
            key_event <= make_hit;
            if (make_hit) begin
                key_reg    <= mapped[7:0];
                held_valid <= 1'b1;
                held_key   <= {cur_ext, scan_code};
            end else if (break_hit) begin
                key_reg    <= 8'h00;
                held_valid <= 1'b0;
                held_key   <= 9'h000;
            end
            if (!cur_ext && scan_code == 8'h12) begin
                if (do_make)       lshift <= 1'b1;
                else if (do_break) lshift <= 1'b0;
            end
            if (!cur_ext && scan_code == 8'h59) begin
                if (do_make)       rshift <= 1'b1;
                else if (do_break) rshift <= 1'b0;
            end
        end
    end

    assign key_code    = {8'h00, key_reg};
    assign caps_active = caps_reg;

endmodule

// File: tb/tb_ps2_keymap.sv
// Scoreboard bench for ps2_keymap: directed sequences plus random byte streams
// checked against a table-driven keyboard model (caps checks when KBD_CAPSLOCK_EN is defined).
module tb_ps2_keymap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        got_code = 1'b0;
    logic [15:0] key_code;
    logic        key_event;
    logic        caps_active;

    ps2_keymap dut (
        .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .got_code(got_code),
        .key_code(key_code), .key_event(key_event), .caps_active(caps_active)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [15:0] key;
        logic        ev;
        logic        caps;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    logic [15:0] last_key = 16'h0000;
    logic        last_caps = 1'b0;

    localparam logic [7:0] LETTERS[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
        8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,
        8'h22,8'h35,8'h1A};
    localparam logic [7:0] DIGITS[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    localparam logic [7:0] PUNCT[11] = '{8'h4E,8'h55,8'h41,8'h49,8'h4A,8'h4C,8'h52,8'h54,8'h5B,8'h5D,8'h0E};
    localparam logic [7:0] FKEYS[12] = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
    localparam logic [7:0] EXTKEYS[10] = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
    localparam logic [7:0] POOL[16] = '{8'h12,8'h59,8'h58,8'h29,8'h5A,8'h66,8'h76,8'h1C,8'h32,
        8'h45,8'h4E,8'h0E,8'h6B,8'h75,8'h05,8'h07};
    localparam logic [7:0] DIG_LO[10] = '{8'h30,8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39};
    localparam logic [7:0] DIG_HI[10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};
    localparam logic [7:0] PUN_LO[11] = '{8'h2D,8'h3D,8'h2C,8'h2E,8'h2F,8'h3B,8'h27,8'h5B,8'h5D,8'h5C,8'h60};
    localparam logic [7:0] PUN_HI[11] = '{8'h5F,8'h2B,8'h3C,8'h3E,8'h3F,8'h3A,8'h22,8'h7B,8'h7D,8'h7C,8'h7E};

    // Keyboard model: pending prefix flags, pause byte budget, modifiers and the held key.
    bit   m_ext, m_brk, m_lsh, m_rsh, m_caps, m_caps_down, m_held_v;
    int   m_pause;
    int   m_key;
    bit [8:0] m_held;

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_down = 0;
        m_held_v = 0; m_pause = 0; m_key = 0; m_held = '0;
    endfunction

    function automatic int model_map(input bit ext, input logic [7:0] b);
        bit sh = m_lsh | m_rsh;
        if (ext) begin
            if (b == 8'h5A) return 128;
            for (int i = 0; i < 10; i++) if (EXTKEYS[i] == b) return 130 + i;
            return -1;
        end
        for (int i = 0; i < 26; i++) if (LETTERS[i] == b) return ((sh ^ m_caps) ? 65 : 97) + i;
        for (int i = 0; i < 10; i++) if (DIGITS[i] == b) return int'(sh ? DIG_HI[i] : DIG_LO[i]);
        for (int i = 0; i < 11; i++) if (PUNCT[i] == b) return int'(sh ? PUN_HI[i] : PUN_LO[i]);
        for (int i = 0; i < 12; i++) if (FKEYS[i] == b) return 141 + i;
        if (b == 8'h29) return 32;
        if (b == 8'h5A) return 128;
        if (b == 8'h66) return 129;
        if (b == 8'h76) return 140;
        return -1;
    endfunction

    function automatic void model_byte(input logic [7:0] b, output exp_t e);
        int v;
        bit ev = 0;
        if (m_pause > 0) begin
            m_pause--;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (!m_ext && !m_brk && b == 8'hE1) begin
            m_pause = 7;
        end else if (!m_ext && !m_brk && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            // protocol chatter, nothing to do
        end else if (m_brk) begin
            if (!m_ext && b == 8'h12) m_lsh = 0;
            if (!m_ext && b == 8'h59) m_rsh = 0;
            if (!m_ext && b == 8'h58) m_caps_down = 0;
            if (m_held_v && m_held == {m_ext, b}) begin
                m_key = 0;
                m_held_v = 0;
            end
            m_ext = 0; m_brk = 0;
        end else begin
            v = model_map(m_ext, b);
            if (v >= 0) begin
                m_key = v; m_held = {m_ext, b}; m_held_v = 1; ev = 1;
            end
            if (!m_ext && b == 8'h12) m_lsh = 1;
            if (!m_ext && b == 8'h59) m_rsh = 1;
`ifdef KBD_CAPSLOCK_EN
            if (!m_ext && b == 8'h58) begin
                if (!m_caps_down) m_caps = !m_caps;
                m_caps_down = 1;
            end
`endif
            m_ext = 0;
        end
        e.key  = 16'(m_key);
        e.ev   = ev;
        e.caps = m_caps;
    endfunction

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Must be entered #1 after a rising edge; consecutive calls strobe on consecutive cycles.
    task automatic apply_stimulus(input logic [7:0] b);
        exp_t e;
        scan_code = b;
        got_code  = 1'b1;
        model_byte(b, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1 got_code = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] bytes[$], input bit gapped);
        foreach (bytes[i]) begin
            apply_stimulus(bytes[i]);
            if (gapped) idle(1);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_count++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    // Monitor: one scoreboard entry per strobed byte, and quiet outputs otherwise.
    initial begin
        exp_t e;
        logic p;
        forever begin
            @(posedge clk);
            p = got_code && rst_n;
            @(negedge clk);
            if (!rst_n) begin
                last_key  = 16'h0000;
                last_caps = 1'b0;
            end else if (p) begin
                if (exp_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL scoreboard_empty: got key %h, expected an entry", key_code);
                end else begin
                    e = exp_q.pop_front();
                    check_output("key_code", key_code, e.key);
                    check_output("key_event", {15'h0, key_event}, {15'h0, e.ev});
                    check_output("caps_active", {15'h0, caps_active}, {15'h0, e.caps});
                    last_key  = e.key;
                    last_caps = e.caps;
                end
            end else begin
                check_output("idle_event", {15'h0, key_event}, 16'h0000);
                check_output("idle_key", key_code, last_key);
                check_output("idle_caps", {15'h0, caps_active}, {15'h0, last_caps});
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r;
        model_reset();
        repeat (3) @(negedge clk);
        check_output("reset_key", key_code, 16'h0000);
        check_output("reset_event", {15'h0, key_event}, 16'h0000);
        check_output("reset_caps", {15'h0, caps_active}, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        send_seq('{8'h1C}, 1);                 wait_drain();
        send_seq('{8'hF0, 8'h1C}, 1);          wait_drain();
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'hF0, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, 1); wait_drain();
        send_seq('{8'hE0, 8'h75, 8'h75, 8'hE0, 8'hF0, 8'h75}, 1); wait_drain();
        send_seq('{8'hE0, 8'h75, 8'h75, 8'hE0, 8'hF0, 8'h75}, 0); wait_drain();
        send_seq('{8'h1C, 8'h32, 8'hF0, 8'h1C, 8'hF0, 8'h32}, 0); wait_drain();
        send_seq('{8'h1C, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hF0, 8'h1C, 8'h1C}, 0);
        wait_drain();
        send_seq('{8'hF0, 8'h1C, 8'h59, 8'h16, 8'h4E, 8'hF0, 8'h59, 8'h16, 8'hAA, 8'h07, 8'hE0, 8'h5A}, 0);
        wait_drain();
        send_seq('{8'hE0, 8'hF0, 8'h5A, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'hF0, 8'h1C, 8'h12, 8'h1C}, 1);
        wait_drain();
        send_seq('{8'hF0, 8'h12, 8'hF0, 8'h1C, 8'h58, 8'hF0, 8'h58}, 0);
        wait_drain();

        // Reset in the middle of an extended sequence must abandon the prefix.
        send_seq('{8'h1C, 8'hE0}, 0);
        wait_drain();
        #5 rst_n = 1'b0;
        model_reset();
        #1;
        check_output("midreset_key", key_code, 16'h0000);
        check_output("midreset_caps", {15'h0, caps_active}, 16'h0000);
        @(posedge clk);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_seq('{8'h6B, 8'h1C}, 0);
        wait_drain();

        for (int i = 0; i < 1500; i++) begin
            int sel = $urandom_range(0, 99);
            if (sel < 14)      r = 8'hF0;
            else if (sel < 22) r = 8'hE0;
            else if (sel < 24) r = 8'hE1;
            else if (sel < 27) r = 8'hAA;
            else if (sel < 60) r = POOL[$urandom_range(0, 15)];
            else if (sel < 80) r = LETTERS[$urandom_range(0, 25)];
            else               r = 8'($urandom_range(0, 255));
            apply_stimulus(r);
            idle($urandom_range(0, 2));
        end
        wait_drain();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
